// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: register indices and enables in, stall/flush/forward controls and counters out.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int RESULTSRC_WIDTH = 2,
  parameter int CNT_WIDTH       = 32
);
  logic [REG_ADDR_WIDTH-1:0]  rs1_D, rs2_D;
  logic [REG_ADDR_WIDTH-1:0]  rs1_E, rs2_E, rd_E;
  logic [REG_ADDR_WIDTH-1:0]  rd_M, rd_W;
  logic                       RegWrite_M, RegWrite_W;
  logic [RESULTSRC_WIDTH-1:0] ResultSrc_E;
  logic                       PCSrc_E;
  logic                       md_E;
  logic                       clr_cnt;

  logic                       Stall_F, Stall_D, Stall_E;
  logic                       Flush_D, Flush_E, Flush_M;
  logic [1:0]                 ForwardA_E, ForwardB_E;
  logic [CNT_WIDTH-1:0]       stall_cycles, flush_events;

  modport master (
    output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
    output RegWrite_M, RegWrite_W, ResultSrc_E, PCSrc_E, md_E, clr_cnt,
    input  Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M,
    input  ForwardA_E, ForwardB_E, stall_cycles, flush_events
  );

  modport slave (
    input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
    input  RegWrite_M, RegWrite_W, ResultSrc_E, PCSrc_E, md_E, clr_cnt,
    output Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M,
    output ForwardA_E, ForwardB_E, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RISC-V core: load-use stalls, redirect flushes,
// RAW forwarding, fixed-latency MUL/DIV hold and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int RESULTSRC_WIDTH = 2,
  parameter int MD_LATENCY      = 4,
  parameter int CNT_WIDTH       = 32
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);
  typedef enum logic {IDLE, BUSY} md_state_e;

  localparam logic [3:0]                 MD_LOAD  = 4'(MD_LATENCY - 2);
  localparam logic [RESULTSRC_WIDTH-1:0] SRC_LOAD = RESULTSRC_WIDTH'(1);

  md_state_e            state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 md_stall, lw_stall;
  logic                 stall_f, stall_d, stall_e;
  logic                 flush_d, flush_e, flush_m;
  logic [1:0]           fwd_a, fwd_b;
  logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

  // Memory-stage producer is younger than Writeback, so it wins.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_WIDTH-1:0] rs,
    input logic [REG_ADDR_WIDTH-1:0] rd_m,
    input logic                      we_m,
    input logic [REG_ADDR_WIDTH-1:0] rd_w,
    input logic                      we_w
  );
    if (we_m && rd_m != '0 && rd_m == rs)      return 2'b10;
    else if (we_w && rd_w != '0 && rd_w == rs) return 2'b01;
    else                                       return 2'b00;
  endfunction

  assign lw_stall = (hz.ResultSrc_E == SRC_LOAD) && (hz.rd_E != '0) &&
                    ((hz.rd_E == hz.rs1_D) || (hz.rd_E == hz.rs2_D));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_stall = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hz.md_E) begin
          md_stall = 1'b1;
          state_d  = BUSY;
          cnt_d    = MD_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          md_stall = 1'b1;
          cnt_d    = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A MUL/DIV hold freezes F/D/E and bubbles MEM; redirects wait until it releases.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    fwd_a   = 2'b00;
    fwd_b   = 2'b00;
    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_m = 1'b1;
    end else begin
      fwd_a = fwd_sel(hz.rs1_E, hz.rd_M, hz.RegWrite_M, hz.rd_W, hz.RegWrite_W);
      fwd_b = fwd_sel(hz.rs2_E, hz.rd_M, hz.RegWrite_M, hz.rd_W, hz.RegWrite_W);
      if (md_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end else begin
        stall_f = lw_stall;
        stall_d = lw_stall;
        flush_d = hz.PCSrc_E;
        flush_e = lw_stall | hz.PCSrc_E;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || hz.clr_cnt) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      if (flush_d && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign hz.Stall_F      = stall_f;
  assign hz.Stall_D      = stall_d;
  assign hz.Stall_E      = stall_e;
  assign hz.Flush_D      = flush_d;
  assign hz.Flush_E      = flush_e;
  assign hz.Flush_M      = flush_m;
  assign hz.ForwardA_E   = fwd_a;
  assign hz.ForwardB_E   = fwd_b;
  assign hz.stall_cycles = stall_cnt_q;
  assign hz.flush_events = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus randomized
// traffic, every cycle compared against a behavioural model of the hazard rules.
module tb_hazard_ctrl;
  localparam int MD_LAT  = 4;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  int md_age = 0;
  int exp_stall_cnt = 0;
  int exp_flush_cnt = 0;

  hazard_ctrl_if #(.REG_ADDR_WIDTH(5), .RESULTSRC_WIDTH(2), .CNT_WIDTH(CW)) hif ();

  hazard_ctrl #(
    .REG_ADDR_WIDTH(5), .RESULTSRC_WIDTH(2), .MD_LATENCY(MD_LAT), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus;
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs;
    hif.rs1_D = '0; hif.rs2_D = '0; hif.rs1_E = '0; hif.rs2_E = '0;
    hif.rd_E = '0;  hif.rd_M = '0;  hif.rd_W = '0;
    hif.RegWrite_M = 1'b0; hif.RegWrite_W = 1'b0; hif.ResultSrc_E = 2'b00;
    hif.PCSrc_E = 1'b0; hif.md_E = 1'b0; hif.clr_cnt = 1'b0;
  endtask

  function automatic logic [1:0] fwdModel(input logic [4:0] rs);
    if (hif.RegWrite_M && hif.rd_M != 0 && hif.rd_M == rs) return 2'b10;
    if (hif.RegWrite_W && hif.rd_W != 0 && hif.rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  // md_age counts how long the current MUL/DIV has sat in EX; it is held until age MD_LAT-1.
  function automatic void modelOutputs(output logic sf, output logic sd, output logic se,
                                       output logic fd, output logic fe, output logic fm,
                                       output logic [1:0] fa, output logic [1:0] fb);
    logic hold, lw;
    hold = hif.md_E && (md_age != MD_LAT - 1);
    lw   = (hif.ResultSrc_E == 2'b01) && (hif.rd_E != 0) &&
           (hif.rd_E == hif.rs1_D || hif.rd_E == hif.rs2_D);
    sf = hold | lw;
    sd = sf;
    se = hold;
    fm = hold;
    fd = !hold && hif.PCSrc_E;
    fe = !hold && (lw || hif.PCSrc_E);
    fa = fwdModel(hif.rs1_E);
    fb = fwdModel(hif.rs2_E);
    if (rst) begin
      sf = 0; sd = 0; se = 0; fd = 1; fe = 1; fm = 1; fa = 2'b00; fb = 2'b00;
    end
  endfunction

  always @(posedge clk) begin : model_update
    logic sf, sd, se, fd, fe, fm;
    logic [1:0] fa, fb;
    modelOutputs(sf, sd, se, fd, fe, fm, fa, fb);
    if (rst) begin
      md_age = 0;
      exp_stall_cnt = 0;
      exp_flush_cnt = 0;
    end else begin
      if (hif.clr_cnt) begin
        exp_stall_cnt = 0;
        exp_flush_cnt = 0;
      end else begin
        if (sf && exp_stall_cnt < CNT_MAX) exp_stall_cnt++;
        if (fd && exp_flush_cnt < CNT_MAX) exp_flush_cnt++;
      end
      if (hif.md_E) md_age = (md_age == MD_LAT - 1) ? 0 : md_age + 1;
      else          md_age = 0;
    end
  end

  always @(negedge clk) begin : compare
    logic sf, sd, se, fd, fe, fm;
    logic [1:0] fa, fb;
    modelOutputs(sf, sd, se, fd, fe, fm, fa, fb);
    checkOutput("Stall_F", 32'(hif.Stall_F), 32'(sf));
    checkOutput("Stall_D", 32'(hif.Stall_D), 32'(sd));
    checkOutput("Stall_E", 32'(hif.Stall_E), 32'(se));
    checkOutput("Flush_D", 32'(hif.Flush_D), 32'(fd));
    checkOutput("Flush_E", 32'(hif.Flush_E), 32'(fe));
    checkOutput("Flush_M", 32'(hif.Flush_M), 32'(fm));
    checkOutput("ForwardA_E", 32'(hif.ForwardA_E), 32'(fa));
    checkOutput("ForwardB_E", 32'(hif.ForwardB_E), 32'(fb));
    checkOutput("stall_cycles", 32'(hif.stall_cycles), 32'(exp_stall_cnt));
    checkOutput("flush_events", 32'(hif.flush_events), 32'(exp_flush_cnt));
  end

  initial begin
    rst = 1'b1;
    clearInputs();
    applyStimulus();
    @(negedge clk);
    checkOutput("rst_flush", {29'd0, hif.Flush_D, hif.Flush_E, hif.Flush_M}, 32'd7);
    checkOutput("rst_stall", {29'd0, hif.Stall_F, hif.Stall_D, hif.Stall_E}, 32'd0);
    checkOutput("rst_cnt", 32'(hif.stall_cycles) + 32'(hif.flush_events), 32'd0);

    applyStimulus();
    rst = 1'b0;
    hif.rs1_E = 5'd5; hif.rd_M = 5'd5; hif.RegWrite_M = 1'b1;
    hif.rd_W = 5'd5; hif.RegWrite_W = 1'b1;
    @(negedge clk);
    checkOutput("fwd_mem", 32'(hif.ForwardA_E), 32'd2);
    applyStimulus();
    hif.RegWrite_M = 1'b0;
    @(negedge clk);
    checkOutput("fwd_wb", 32'(hif.ForwardA_E), 32'd1);
    applyStimulus();
    hif.RegWrite_M = 1'b1; hif.rd_M = 5'd0; hif.rd_W = 5'd0;
    @(negedge clk);
    checkOutput("fwd_x0", 32'(hif.ForwardA_E), 32'd0);

    applyStimulus();
    clearInputs();
    hif.ResultSrc_E = 2'b01; hif.rd_E = 5'd7; hif.rs2_D = 5'd7;
    @(negedge clk);
    checkOutput("lu_stall", {30'd0, hif.Stall_F, hif.Stall_D}, 32'd3);
    checkOutput("lu_flush", {30'd0, hif.Flush_E, hif.Flush_D}, 32'd2);
    checkOutput("lu_cnt_before", 32'(hif.stall_cycles), 32'd0);
    applyStimulus();
    clearInputs();
    @(negedge clk);
    checkOutput("lu_cnt_after", 32'(hif.stall_cycles), 32'd1);

    applyStimulus();
    hif.PCSrc_E = 1'b1;
    @(negedge clk);
    checkOutput("redir_flush", {30'd0, hif.Flush_D, hif.Flush_E}, 32'd3);
    checkOutput("redir_cnt_before", 32'(hif.flush_events), 32'd0);
    applyStimulus();
    hif.PCSrc_E = 1'b0;
    @(negedge clk);
    checkOutput("redir_released", {30'd0, hif.Flush_D, hif.Flush_E}, 32'd0);
    checkOutput("redir_cnt_after", 32'(hif.flush_events), 32'd1);

    applyStimulus();
    hif.clr_cnt = 1'b1;
    for (int i = 0; i < MD_LAT; i++) begin
      applyStimulus();
      hif.clr_cnt = 1'b0;
      hif.md_E = 1'b1;
      hif.PCSrc_E = (i == 1);
      @(negedge clk);
      checkOutput($sformatf("md_stall_e_%0d", i), 32'(hif.Stall_E), (i < MD_LAT - 1) ? 32'd1 : 32'd0);
      checkOutput($sformatf("md_flush_m_%0d", i), 32'(hif.Flush_M), (i < MD_LAT - 1) ? 32'd1 : 32'd0);
      if (i == 1) checkOutput("md_redirect_blocked", 32'(hif.Flush_D), 32'd0);
    end
    applyStimulus();
    clearInputs();
    @(negedge clk);
    checkOutput("md_stall_cycles", 32'(hif.stall_cycles), 32'd3);
    checkOutput("md_flush_events", 32'(hif.flush_events), 32'd0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      hif.md_E = 1'b1;
      rst = (i == 1);
      @(negedge clk);
      if (i == 1) checkOutput("rstbusy_forced", 32'(hif.Stall_E), 32'd0);
      if (i == 2) begin
        checkOutput("rstbusy_fresh", 32'(hif.Stall_E), 32'd1);
        checkOutput("rstbusy_cnt", 32'(hif.stall_cycles) + 32'(hif.flush_events), 32'd0);
      end
      if (i == 5) checkOutput("rstbusy_advance", 32'(hif.Stall_E), 32'd0);
    end
    applyStimulus();
    clearInputs();

    for (int i = 0; i < 18; i++) begin
      applyStimulus();
      hif.ResultSrc_E = 2'b01; hif.rd_E = 5'd3; hif.rs1_D = 5'd3;
    end
    applyStimulus();
    hif.clr_cnt = 1'b1;
    @(negedge clk);
    checkOutput("sat_stick", 32'(hif.stall_cycles), 32'd15);
    applyStimulus();
    hif.clr_cnt = 1'b0;
    @(negedge clk);
    checkOutput("sat_clear_wins", 32'(hif.stall_cycles), 32'd0);
    applyStimulus();
    clearInputs();

    for (int i = 0; i < 400; i++) begin
      applyStimulus();
      rst = ($urandom_range(63) == 0);
      hif.rs1_D = 5'($urandom_range(3)); hif.rs2_D = 5'($urandom_range(3));
      hif.rs1_E = 5'($urandom_range(3)); hif.rs2_E = 5'($urandom_range(3));
      hif.rd_E  = 5'($urandom_range(3)); hif.rd_M  = 5'($urandom_range(3));
      hif.rd_W  = 5'($urandom_range(3));
      hif.RegWrite_M = 1'($urandom_range(1)); hif.RegWrite_W = 1'($urandom_range(1));
      hif.ResultSrc_E = 2'($urandom_range(3));
      hif.PCSrc_E = ($urandom_range(5) == 0);
      hif.clr_cnt = ($urandom_range(31) == 0);
      hif.md_E = (md_age > 0) ? 1'b1 : ($urandom_range(7) == 0);
    end
    applyStimulus();
    rst = 1'b0;
    clearInputs();
    applyStimulus();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It produces the stall, flush and forwarding controls that the IF/ID, ID/EX and EX/MEM pipeline registers and the EX-stage operand muxes consume, most notably `Flush_E` for the ID/EX register. It detects load-use hazards, branch/jump redirects and RAW forwarding. It also holds the pipeline for a fixed-latency multi-cycle MUL/DIV instruction in EX and keeps saturating stall/flush event counters.

## Interface
Parameters:
- `REG_ADDR_WIDTH`, 5, register index width.
- `RESULTSRC_WIDTH`, 2, width of `ResultSrc_E`.
- `MD_LATENCY`, 4, total EX-occupancy cycles of a MUL/DIV instruction; legal range 2..16.
- `CNT_WIDTH`, 32, width of each performance counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active high.
- `rs1_D`, `rs2_D`  in  REG_ADDR_WIDTH  source registers in Decode.
- `rs1_E`, `rs2_E`, `rd_E`  in  REG_ADDR_WIDTH  source and destination registers in Execute.
- `rd_M`, `rd_W`  in  REG_ADDR_WIDTH  destination registers in Memory and Writeback.
- `RegWrite_M`, `RegWrite_W`  in  1  register-write enables in Memory and Writeback.
- `ResultSrc_E`  in  RESULTSRC_WIDTH  value 2'b01 means the EX instruction is a load.
- `PCSrc_E`  in  1  taken branch or jump resolved in EX.
- `md_E`  in  1  the EX instruction is MUL/DIV; stays high while that instruction is held.
- `clr_cnt`  in  1  synchronous clear of both counters.
- `Stall_F`, `Stall_D`, `Stall_E`  out  1  hold the PC, IF/ID and ID/EX stages.
- `Flush_D`, `Flush_E`, `Flush_M`  out  1  bubble into IF/ID, ID/EX and EX/MEM.
- `ForwardA_E`, `ForwardB_E`  out  2  forwarding select: 00 = register file, 01 = Writeback result, 10 = Memory ALU result.
- `stall_cycles`  out  CNT_WIDTH  count of cycles with `Stall_F` = 1.
- `flush_events`  out  CNT_WIDTH  count of cycles with `Flush_D` = 1.

## Operation
- **Forwarding (combinational).** The rule for `ForwardA_E` is below; `ForwardB_E` is identical with `rs2_E` in place of `rs1_E`.
  - 10 if `RegWrite_M` && `rd_M` != 0 && `rd_M` == `rs1_E`.
  - Otherwise 01 if `RegWrite_W` && `rd_W` != 0 && `rd_W` == `rs1_E`.
  - Otherwise 00. The Memory-stage match has priority.
- **Load-use detection.** `lw_stall` = (`ResultSrc_E` == 2'b01) && `rd_E` != 0 && (`rd_E` == `rs1_D` || `rd_E` == `rs2_D`).
- **MUL/DIV FSM.** State encoding IDLE/BUSY, with a 4-bit down-counter `cnt`.
  - IDLE with `md_E` = 1: `md_stall` = 1; next state BUSY; `cnt` <= MD_LATENCY-2.
  - BUSY with `cnt` != 0: `md_stall` = 1; `cnt` <= `cnt`-1.
  - BUSY with `cnt` == 0: `md_stall` = 0; next state IDLE. The MUL/DIV instruction advances this cycle.
- **Output equations when `md_stall` = 1.**
  - `Stall_F` = `Stall_D` = `Stall_E` = 1 and `Flush_M` = 1.
  - `Flush_D` = `Flush_E` = 0; `PCSrc_E` and `lw_stall` are ignored.
- **Output equations when `md_stall` = 0.**
  - `Stall_F` = `Stall_D` = `lw_stall`; `Stall_E` = 0; `Flush_M` = 0.
  - `Flush_D` = `PCSrc_E`.
  - `Flush_E` = `lw_stall` | `PCSrc_E`.
- **Counters.**
  - `stall_cycles` increments on each edge where `Stall_F` = 1; `flush_events` increments on each edge where `Flush_D` = 1.
  - Both saturate at all-ones.
  - `clr_cnt` = 1 zeroes both counters, overriding the increment in that same cycle.

## Timing
- **Latency.** Stall, flush and forward outputs are combinational from the inputs and the current state, so they are valid in the same cycle. Counters and FSM state update on the next rising edge.
- **Reset (`rst` = 1 at an edge).**
  - State becomes IDLE, `cnt` = 0, `stall_cycles` = 0, `flush_events` = 0.
  - While `rst` is high the outputs are forced: `Flush_D` = `Flush_E` = `Flush_M` = 1, all stalls 0, forwards 00.
  - Reset mid-BUSY aborts the hold immediately.
- **MUL/DIV hold length.** A MUL/DIV instruction is held exactly MD_LATENCY-1 cycles, then advances on cycle MD_LATENCY.
  - With MD_LATENCY = 2 the hold is exactly one cycle.
  - Back-to-back MUL/DIV: the second one enters EX while the FSM is in IDLE and starts a new hold with no gap cycle.
- **Load-use plus redirect.** Simultaneous `lw_stall` and `PCSrc_E` give `Flush_D` = 1, `Flush_E` = 1 and `Stall_F` = `Stall_D` = 1. The flush wins at IF/ID, because the register applies flush over stall.
- **Zero register.** `rd` = 0 never forwards and never load-stalls.

## Test plan
- **Forwarding.** Drive `rs1_E` = 5, `rd_M` = 5 with `RegWrite_M` = 1, and `rd_W` = 5 with `RegWrite_W` = 1. Expect `ForwardA_E` = 10. Drop `RegWrite_M`: expect 01. Set `rd_M` = `rd_W` = 0 (writes still enabled): expect 00.
- **Load-use.** Drive `ResultSrc_E` = 01, `rd_E` = 7, `rs2_D` = 7. Expect `Stall_F` = `Stall_D` = `Flush_E` = 1, `Flush_D` = 0; `stall_cycles` increments by 1.
- **Redirect.** Pulse `PCSrc_E` for one cycle. Expect `Flush_D` = `Flush_E` = 1 for that cycle only; `flush_events` goes 0 -> 1.
- **MUL/DIV hold, MD_LATENCY = 4.** Hold `md_E` high for 4 cycles. Expect `Stall_E` = `Flush_M` = 1 in cycles 0-2 and 0 in cycle 3. During the hold, assert `PCSrc_E`: expect `Flush_D` = 0. Final `stall_cycles` = 3.
- **Reset mid-BUSY.** Assert `rst` in cycle 1 of a hold. Next cycle: state IDLE, counters 0, and `Stall_E` follows `md_E` afresh.
- **Saturation and clear.** Preload `stall_cycles` near max (CNT_WIDTH = 4) and stall continuously. Expect it to stick at 15. Assert `clr_cnt` together with a stall: expect 0, not 1.
